instr_fetch: RTL and testbench

Program sequencer that sits directly upstream of the 4-bit processor and drives its `instruction` input. It holds a small loadable instruction store, accepts a program over a valid/ready load port, then issues one instruction per clock from a program counter. Issue supports stall, wrap-around looping and a HALT opcode. Whenever no valid instruction is issued, the block presents NOP so the processor always sees a defined opcode.

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/instr_mem.sv | 22 ++
 rtl/instr_fetch.sv | 154 +++++++++++++++
 tb/tb_instr_fetch.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and opcodes for the instruction sequencer and the processor decode.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  localparam logic [3:0] HALT_OP = 4'hF;
  localparam logic [3:0] NOP_OP  = 4'h0;

endpackage

// File: rtl/instr_mem.sv
// Instruction store: synchronous write, asynchronous read, contents not reset.
module instr_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [3:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [3:0]        rdata
);

  logic [3:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Program sequencer: loads a program over valid/ready, then issues one opcode
// per clock to the processor, with stall, wrap-around looping and HALT.
//
// state  | meaning
// IDLE   | no load in progress; program (if any) ready to start
// LOAD   | accepting words at wr_ptr
// RUN    | issuing mem[pc] each unstalled cycle
// HALT   | HALT_OP reached; NOP presented until start
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [3:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  input  logic              stall,
  output logic [3:0]        instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int PTR_W = ADDR_W + 1;

  fetch_state_t      state, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]  prog_len, prog_len_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [3:0]        instr_nxt;
  logic              valid_nxt;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [3:0]        rdata;
  logic              accept;
  logic              last_word;

  instr_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (load_data),
    .raddr (pc),
    .rdata (rdata)
  );

  // wr_ptr carries one extra bit so that "full" (== DEPTH) is representable
  assign load_ready = ((state == S_IDLE) || (state == S_LOAD)) && !wr_ptr[ADDR_W];
  assign accept     = load_valid && load_ready;
  assign halted     = (state == S_HALT);
  assign last_word  = ({1'b0, pc} == (prog_len - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      wr_ptr      <= '0;
      prog_len    <= '0;
      instruction <= NOP_OP;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      wr_ptr      <= wr_ptr_nxt;
      prog_len    <= prog_len_nxt;
      instruction <= instr_nxt;
      instr_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    wr_ptr_nxt   = wr_ptr;
    prog_len_nxt = prog_len;
    instr_nxt    = instruction;
    valid_nxt    = instr_valid;
    we           = 1'b0;
    waddr        = wr_ptr[ADDR_W-1:0];

    if (clear) begin
      state_nxt    = S_IDLE;
      pc_nxt       = '0;
      wr_ptr_nxt   = '0;
      prog_len_nxt = '0;
      instr_nxt    = NOP_OP;
      valid_nxt    = 1'b0;
    end else if (start && (((state == S_IDLE) && (prog_len != '0)) || (state == S_HALT))) begin
      state_nxt = S_RUN;
      pc_nxt    = '0;
      instr_nxt = NOP_OP;
      valid_nxt = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // a load from IDLE always starts a fresh program at address 0
          if (accept) begin
            we    = 1'b1;
            waddr = '0;
            if (load_last) begin
              prog_len_nxt = PTR_W'(1);
              wr_ptr_nxt   = '0;
            end else begin
              prog_len_nxt = '0;
              wr_ptr_nxt   = PTR_W'(1);
              state_nxt    = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            we = 1'b1;
            if (load_last) begin
              prog_len_nxt = wr_ptr + 1'b1;
              wr_ptr_nxt   = '0;
              state_nxt    = S_IDLE;
            end else begin
              wr_ptr_nxt = wr_ptr + 1'b1;
            end
          end else if (wr_ptr[ADDR_W] && load_last && !load_valid) begin
            prog_len_nxt = PTR_W'(DEPTH);
            wr_ptr_nxt   = '0;
            state_nxt    = S_IDLE;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (rdata != HALT_OP) begin
              instr_nxt = rdata;
              valid_nxt = 1'b1;
              pc_nxt    = last_word ? '0 : pc + 1'b1;
            end else begin
              instr_nxt = NOP_OP;
              valid_nxt = 1'b0;
              state_nxt = S_HALT;
            end
          end
        end
        S_HALT: begin
          instr_nxt = NOP_OP;
          valid_nxt = 1'b0;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: load, loop, stall, halt, full store, clear, reset.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       load_valid;
  logic [3:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       start;
  logic       stall;
  logic [3:0] instruction;
  logic       instr_valid;
  logic [3:0] pc;
  logic       halted;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .start       (start),
    .stall       (stall),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ins, input logic v,
                           input logic [3:0] p, input logic h);
    check({tag, ".instr"}, {4'h0, instruction}, {4'h0, ins});
    check({tag, ".valid"}, {7'h0, instr_valid}, {7'h0, v});
    check({tag, ".pc"}, {4'h0, pc}, {4'h0, p});
    check({tag, ".halted"}, {7'h0, halted}, {7'h0, h});
  endtask

  task automatic load_word(input logic [3:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = 4'h0;
    load_last = 1'b0; start = 1'b0; stall = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check_out("reset", 4'h0, 1'b0, 4'h0, 1'b0);
    check("reset.load_ready", {7'h0, load_ready}, 8'h01);

    // start with empty program is ignored
    pulse_start();
    step();
    check_out("empty_start", 4'h0, 1'b0, 4'h0, 1'b0);
    check("empty_start.ready", {7'h0, load_ready}, 8'h01);

    // two-word loop 1,2
    load_word(4'h1, 1'b0);
    load_word(4'h2, 1'b1);
    pulse_start();
    check_out("loop.edgeN", 4'h0, 1'b0, 4'h0, 1'b0);
    step(); check_out("loop.w0", 4'h1, 1'b1, 4'h1, 1'b0);
    step(); check_out("loop.w1", 4'h2, 1'b1, 4'h0, 1'b0);
    step(); check_out("loop.w2", 4'h1, 1'b1, 4'h1, 1'b0);
    step(); check_out("loop.w3", 4'h2, 1'b1, 4'h0, 1'b0);

    // stall for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_out("stall", 4'h2, 1'b1, 4'h0, 1'b0);
    end
    stall = 1'b0;
    step(); check_out("resume.a", 4'h1, 1'b1, 4'h1, 1'b0);
    step(); check_out("resume.b", 4'h2, 1'b1, 4'h0, 1'b0);

    // clear wins over start in RUN
    clear = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    check_out("clear", 4'h0, 1'b0, 4'h0, 1'b0);
    check("clear.ready", {7'h0, load_ready}, 8'h01);
    pulse_start();
    step();
    check_out("clear.start_ignored", 4'h0, 1'b0, 4'h0, 1'b0);

    // HALT program 3,F,5
    load_word(4'h3, 1'b0);
    load_word(4'hF, 1'b0);
    load_word(4'h5, 1'b1);
    pulse_start();
    step(); check_out("halt.w0", 4'h3, 1'b1, 4'h1, 1'b0);
    step(); check_out("halt.hit", 4'h0, 1'b0, 4'h1, 1'b1);
    step(); check_out("halt.hold", 4'h0, 1'b0, 4'h1, 1'b1);
    check("halt.ready", {7'h0, load_ready}, 8'h00);
    pulse_start();
    check_out("halt.restart", 4'h0, 1'b0, 4'h0, 1'b0);
    step(); check_out("halt.reissue", 4'h3, 1'b1, 4'h1, 1'b0);
    clear = 1'b1; step(); clear = 1'b0;

    // full 16-word store, no load_last
    for (int i = 0; i < 16; i++) begin
      load_word(4'((i % 7) + 1), 1'b0);
      check("full.ready", {7'h0, load_ready}, (i < 15) ? 8'h01 : 8'h00);
    end
    load_word(4'h9, 1'b0);
    check("full.reject17", {7'h0, load_ready}, 8'h00);
    load_last = 1'b1; step(); load_last = 1'b0;
    check("full.last_idle", {7'h0, load_ready}, 8'h01);
    pulse_start();
    for (int i = 0; i < 18; i++) begin
      step();
      check_out("full.run", 4'(((i % 16) % 7) + 1), 1'b1, 4'((i + 1) % 16), 1'b0);
    end

    // reset mid-RUN
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check_out("rst_run", 4'h0, 1'b0, 4'h0, 1'b0);
    check("rst_run.ready", {7'h0, load_ready}, 8'h01);
    pulse_start();
    step();
    check_out("rst_run.start_ignored", 4'h0, 1'b0, 4'h0, 1'b0);

    // single-word program loops on itself
    load_word(4'h7, 1'b1);
    pulse_start();
    step(); check_out("single.a", 4'h7, 1'b1, 4'h0, 1'b0);
    step(); check_out("single.b", 4'h7, 1'b1, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
